// File: rtl/ps2_tastatura_pkg.sv
// ps2_tastatura_pkg: scan codes, decoder states and default timing for the PS/2 paddle keyboard
package ps2_tastatura_pkg;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DOWN = 8'h72;
    localparam int FILTER_LEN_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dek_state_e;
endpackage

// File: rtl/ps2_tastatura_if.sv
// ps2_tastatura_if: keyboard pins plus received byte, error pulse and held paddle keys
interface ps2_tastatura_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] kod;
    logic       kod_valid;
    logic       greska;
    logic       gore1;
    logic       dole1;
    logic       gore2;
    logic       dole2;
    modport master (output ps2_clk, ps2_dat, input kod, kod_valid, greska, gore1, dole1, gore2, dole2);
    modport slave  (input ps2_clk, ps2_dat, output kod, kod_valid, greska, gore1, dole1, gore2, dole2);
endinterface

// File: rtl/ps2_okvir.sv
// ps2_okvir: PS/2 pin conditioning and 11-bit frame receiver; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_okvir
    import ps2_tastatura_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kod,
    output logic       kod_valid,
    output logic       greska
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    logic [1:0]    clk_s, dat_s;
    logic          filt, filt_d;
    logic [FW-1:0] f_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    sh;
    logic [TW-1:0] to_cnt;
    logic          strobe, dat, frame_bad;
    assign dat       = dat_s[1];
    assign strobe    = filt_d & ~filt;
    assign frame_bad = ~dat | (PAR_EN & ~(^sh));
    // synchronise both pins and debounce the clock; filter idles high like the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s  <= 2'b11;
            dat_s  <= 2'b11;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            f_cnt  <= '0;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            dat_s  <= {dat_s[0], ps2_dat};
            filt_d <= filt;
            if (clk_s[1] == filt)
                f_cnt <= '0;
            else if (f_cnt == FW'(FILTER_LEN - 1)) begin
                filt  <= clk_s[1];
                f_cnt <= '0;
            end else
                f_cnt <= f_cnt + 1'b1;
        end
    end
    // shift in one bit per strobe, check framing at start/stop, abort stalled frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            sh        <= '0;
            to_cnt    <= '0;
            kod       <= '0;
            kod_valid <= 1'b0;
            greska    <= 1'b0;
        end else begin
            kod_valid <= 1'b0;
            greska    <= 1'b0;
            if (strobe) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    bit_cnt <= dat ? 4'd0 : 4'd1;
                    greska  <= dat;
                end else if (bit_cnt == 4'd10) begin
                    bit_cnt   <= '0;
                    greska    <= frame_bad;
                    kod_valid <= ~frame_bad;
                    if (!frame_bad)
                        kod <= sh[7:0];
                end else begin
                    sh      <= {dat, sh[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    to_cnt  <= '0;
                    bit_cnt <= '0;
                    greska  <= 1'b1;
                end else
                    to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_tastatura.sv
// ps2_tastatura: PS/2 keyboard to paddle keys (W/S player 1, Up/Down player 2); PS2_PARITY_CHECK_EN enables parity rejection
module ps2_tastatura
    import ps2_tastatura_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    ps2_tastatura_if.slave bus
);
    logic [7:0] kod;
    logic       kod_valid, greska, brk, ext;
    logic [3:0] keys, keys_n;
    dek_state_e state, state_n;
    ps2_okvir #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_okvir (
        .clk       (CLOCK_50),
        .rst       (reset),
        .ps2_clk   (bus.ps2_clk),
        .ps2_dat   (bus.ps2_dat),
        .kod       (kod),
        .kod_valid (kod_valid),
        .greska    (greska)
    );
    assign bus.kod       = kod;
    assign bus.kod_valid = kod_valid;
    assign bus.greska    = greska;
    assign {bus.dole2, bus.gore2, bus.dole1, bus.gore1} = keys;
    assign brk = (state == BRK) || (state == EXT_BRK);
    assign ext = (state == EXT) || (state == EXT_BRK);
    // decoder state and held key levels
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            keys  <= '0;
        end else begin
            state <= state_n;
            keys  <= keys_n;
        end
    end
    // prefix tracking and make/break application for the four mapped keys
    always_comb begin
        state_n = state;
        keys_n  = keys;
        if (greska)
            state_n = IDLE;
        else if (kod_valid) begin
            if (!brk && kod == SC_EXT)
                state_n = EXT;
            else if (!brk && kod == SC_BRK)
                state_n = ext ? EXT_BRK : BRK;
            else begin
                state_n = IDLE;
                if (!ext && kod == SC_W)    keys_n[0] = ~brk;
                if (!ext && kod == SC_S)    keys_n[1] = ~brk;
                if (ext && kod == SC_UP)    keys_n[2] = ~brk;
                if (ext && kod == SC_DOWN)  keys_n[3] = ~brk;
            end
        end
    end
endmodule

// File: tb/tb_ps2_tastatura.sv
// tb_ps2_tastatura: directed frames with hand-computed scan codes, key levels and error pulses
module tb_ps2_tastatura;
    localparam int FL = 8;
    localparam int TO = 300;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, kv_n = 0, kv_cyc = 0, gr_hi = 0, gr_rise = 0, overlap = 0, g1_dly = -1;
    logic gr_prev = 1'b0, g1_prev = 1'b0;
    int   kv0, gr0;
    ps2_tastatura_if bus ();
    ps2_tastatura #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.kod_valid) begin
            kv_n++;
            kv_cyc = cyc;
        end
        if (bus.greska) gr_hi++;
        if (bus.greska && !gr_prev) gr_rise++;
        if (bus.greska && bus.kod_valid) overlap++;
        if (bus.gore1 !== g1_prev) g1_dly = cyc - kv_cyc;
        gr_prev = bus.greska;
        g1_prev = bus.gore1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_bit(input logic b, input bit g);
        bus.ps2_dat = b;
        wait_cyc(4);
        bus.ps2_clk = 1'b0;
        wait_cyc(20);
        bus.ps2_clk = 1'b1;
        wait_cyc(20);
        if (g) begin
            bus.ps2_clk = 1'b0;
            wait_cyc(FL - 1);
            bus.ps2_clk = 1'b1;
            wait_cyc(14);
        end
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit g);
        send_bit(1'b0, g);
        for (int i = 0; i < 8; i++) send_bit(b[i], g);
        send_bit(~(^b) ^ bad_par, g);
        send_bit(1'b1, g);
        bus.ps2_dat = 1'b1;
        wait_cyc(10);
    endtask
    function automatic logic [31:0] keys();
        return {28'd0, bus.dole2, bus.gore2, bus.dole1, bus.gore1};
    endfunction
    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        wait_cyc(5);
        chk("reset_kod", bus.kod, 8'h00);
        chk("reset_kv", bus.kod_valid, 1'b0);
        chk("reset_gr", bus.greska, 1'b0);
        chk("reset_keys", keys(), 4'b0000);
        rst = 1'b0;
        wait_cyc(30);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        bus.ps2_dat = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(20);
        send_frame(8'h1D, 0, 0);
        chk("midreset_no_err", gr_rise, 0);
        chk("midreset_kod", bus.kod, 8'h1D);
        chk("w_make_keys", keys(), 4'b0001);
        chk("w_make_dly", g1_dly, 1);
        g1_dly = -1;
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        chk("w_break_keys", keys(), 4'b0000);
        chk("w_break_dly", g1_dly, 1);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        chk("up_make_keys", keys(), 4'b0100);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        chk("up_break_keys", keys(), 4'b0000);
        send_frame(8'h1D, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h1D, 0, 0);
        chk("ext_1d_unmapped", keys(), 4'b0001);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        chk("w_clear", keys(), 4'b0000);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h72, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h72, 0, 0);
        chk("down_repeat", keys(), 4'b1000);
        send_frame(8'h1D, 0, 0);
        send_frame(8'h1B, 0, 0);
        chk("p1_both", keys(), 4'b1011);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1B, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h72, 0, 0);
        chk("all_clear", keys(), 4'b0000);
        chk("kod_72", bus.kod, 8'h72);
        gr0 = gr_rise;
        send_bit(1'b1, 0);
        wait_cyc(10);
        chk("start_err", gr_rise - gr0, 1);
        kv0 = kv_n;
        gr0 = gr_rise;
        send_frame(8'h1D, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_kv", kv_n - kv0, 0);
        chk("par_err", gr_rise - gr0, 1);
        chk("par_kod", bus.kod, 8'h72);
`else
        chk("par_kv", kv_n - kv0, 1);
        chk("par_err", gr_rise - gr0, 0);
        chk("par_kod", bus.kod, 8'h1D);
`endif
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        gr0 = gr_rise;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        bus.ps2_dat = 1'b1;
        wait_cyc(TO + 60);
        chk("timeout_err", gr_rise - gr0, 1);
        send_frame(8'h1B, 0, 0);
        chk("after_to_kod", bus.kod, 8'h1B);
        chk("after_to_keys", keys(), 4'b0010);
        kv0 = kv_n;
        gr0 = gr_rise;
        send_frame(8'h75, 0, 1);
        chk("glitch_kv", kv_n - kv0, 1);
        chk("glitch_err", gr_rise - gr0, 0);
        chk("glitch_kod", bus.kod, 8'h75);
        chk("glitch_keys", keys(), 4'b0010);
        chk("gr_one_cycle", gr_hi, gr_rise);
        chk("kv_gr_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_tastatura.md
# ps2_tastatura

PS/2 keyboard receiver and paddle-key decoder for the pong top level. It replaces the on-board KEY buttons as the player input source. It deserialises the keyboard's clock/data frames into scan-code bytes, then tracks make/break codes for four keys: W/S for player 1, Up/Down arrows for player 2. It presents them as held level signals to the existing key handler.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYC, 100000: CLOCK_50 cycles without a falling edge, mid-frame, before the frame is aborted (2 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; sole clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock pin, asynchronous.
- ps2_dat  in  1  raw keyboard data pin, asynchronous.
- kod  out  8  last correctly received scan-code byte.
- kod_valid  out  1  one-cycle pulse: kod has been updated.
- greska  out  1  one-cycle pulse on a framing, parity or timeout error.
- gore1, dole1  out  1  W / S held (player 1 up / down).
- gore2, dole2  out  1  Up / Down arrow held (player 2 up / down).

## Operation
- **Input conditioning:**
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - The synchronised clock feeds a glitch filter. The filtered level changes only after FILTER_LEN equal consecutive samples.
  - A falling edge of the filtered clock is a bit strobe. ps2_dat (synchronised) is sampled on the strobe cycle.
- **Frame receiver:** 11 bits per frame.
  - Bit 0: start bit, must be 0.
  - Bits 1–8: data, LSB first.
  - Bit 9: parity, odd over data plus parity.
  - Bit 10: stop bit, must be 1.
- **Frame checks:**
  - A start bit of 1 aborts the frame immediately. greska pulses and the bit counter returns to 0.
  - A stop bit of 0, or bad parity (see Configuration), discards the byte and pulses greska.
  - The timeout counter runs only while the bit counter is nonzero and clears on every strobe. On reaching TIMEOUT_CYC it aborts the frame: greska pulses and the counter returns to 0.
  - A good frame loads kod and pulses kod_valid.
- **Decoder FSM:** states IDLE, BRK, EXT, EXT_BRK. It consumes each kod_valid byte.
  - IDLE: E0 → EXT; F0 → BRK; other → make(code, ext=0), stay IDLE.
  - EXT: F0 → EXT_BRK; E0 → stay EXT; other → make(code, ext=1), go IDLE.
  - BRK: any byte → break(code, ext=0), go IDLE.
  - EXT_BRK: any byte → break(code, ext=1), go IDLE.
- **Key map:**
  - 1D (no ext) → gore1.
  - 1B (no ext) → dole1.
  - E0 75 → gore2.
  - E0 72 → dole2.
  - make sets the mapped output to 1; break clears it. Unmapped codes change no output.
- **Decoder edge cases:**
  - Typematic repeats of a make code are idempotent.
  - Both up and down of one player may be 1 simultaneously; arbitration belongs to the consumer.
  - greska returns the decoder FSM to IDLE. Key levels are left unchanged.

## Timing
- **Reset:** kod=00, kod_valid=0, greska=0, all key outputs 0. The bit counter, timeout counter, filter and FSM are cleared. The filter output resets to 1 (idle bus). Reset asserted mid-frame drops the partial frame without a greska pulse.
- **Strobe latency:** 2 synchroniser cycles + FILTER_LEN filter cycles + 1 edge-detect cycle after the pin falls.
- **Byte output:** kod and kod_valid update on the cycle after the stop-bit strobe.
- **Key outputs:** update on the cycle after kod_valid. The total is 1 cycle of registered decode.
- **Error pulse:** greska is high for exactly one cycle, the cycle after the offending strobe or the timeout expiry.
- **Simultaneous events:** kod_valid and greska are never high in the same cycle. A strobe in the same cycle the timeout expires is treated as the strobe, and the timeout is not taken.

## Configuration
- PS2_PARITY_CHECK_EN defined: parity mismatch discards the byte and pulses greska.
- Not defined: the parity bit is shifted in but ignored; any byte with valid start and stop bits is accepted.

## Structure
- **Shared package:**
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_W=1D, SC_S=1B, SC_UP=75, SC_DOWN=72.
  - The decoder-state typedef.
  - Default FILTER_LEN and TIMEOUT_CYC.
- **Sub-module ps2_okvir:** holds the synchroniser, filter, bit counter, timeout and frame checks, and outputs kod, kod_valid and greska. The top holds the decoder FSM and key map.

## Test plan
- **Reset state:** Reset asserted mid-frame, then W make sent → no greska; kod=1D, gore1=1.
- **Player 1 make/break:** Send 1D, then F0 1D → gore1 rises 1 cycle after the first kod_valid and falls 1 cycle after the third.
- **Player 2 make/break:** Send E0 75, then E0 F0 75 → gore2=1 then 0. gore1 and dole1 stay 0. An unmapped E0 1D leaves gore1 untouched.
- **Parity error:** Frame 1D with even parity → with PS2_PARITY_CHECK_EN, greska pulse and no kod_valid; without it, kod=1D.
- **Timeout:** 5 bits sent, then the clock held high for TIMEOUT_CYC cycles → greska one cycle. A following clean 1B frame gives dole1=1.
- **Glitch rejection:** ps2_clk low glitches of FILTER_LEN-1 cycles inside a valid frame → no extra strobes; the byte is received correctly.
